// File: rtl/status_array_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// status_array_arbiter_pkg
// Shared widths, request layouts and FSM state encoding for the status array
// arbiter. These are the geometry parameters of the status array (row
// address width, row width, number of independently writable blocks per row).
// -----------------------------------------------------------------------------
package status_array_arbiter_pkg;

    localparam int ADDR_WIDTH = 4;
    localparam int ROW_WIDTH  = 8;
    localparam int NUM_BLOCKS = 4;

    typedef enum logic [0:0] {
        ST_WAIT_RDY = 1'b0,
        ST_RUN      = 1'b1
    } arb_state_e;

    // Update request as captured in its holding register.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [ROW_WIDTH-1:0]  data;
        logic [NUM_BLOCKS-1:0] wmask;
    } upd_req_t;

    localparam int UPD_REQ_W = $bits(upd_req_t);

    // Saturating increment for the 4-bit starvation counter.
    function automatic logic [3:0] sat_inc4(input logic [3:0] val);
        logic [3:0] res;
        if (val == 4'hF) begin
            res = val;
        end else begin
            res = val + 4'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/status_req_holder.sv
// -----------------------------------------------------------------------------
// status_req_holder
// One-entry holding register for a request port. A load overrides an issue on
// the same edge, so a port can accept a new request while its held one is
// being issued.
// Ports:
//   clk, arst      clock, asynchronous active-high reset (empties the entry)
//   i_load         capture i_data (entry becomes full)
//   i_issue        held request leaves (entry becomes empty unless loaded)
//   i_data         request payload
//   o_full         entry holds a request
//   o_data         held payload
// -----------------------------------------------------------------------------
module status_req_holder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             i_load,
    input  logic             i_issue,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    output logic [WIDTH-1:0] o_data
);

    logic             full_d, full_q;
    logic [WIDTH-1:0] data_d, data_q;

    // Next entry state: load wins over issue.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (i_load) begin
            full_d = 1'b1;
            data_d = i_data;
        end else if (i_issue) begin
            full_d = 1'b0;
        end else begin
            full_d = full_q;
        end
    end

    // Entry registers.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            full_q <= 1'b0;
            data_q <= {WIDTH{1'b0}};
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign o_full = full_q;
    assign o_data = data_q;

endmodule

// File: rtl/status_array_arbiter.sv
// -----------------------------------------------------------------------------
// status_array_arbiter
// Arbitrates a lookup port and a status-update port onto a single status
// array request channel. Each port has a one-entry holding register; updates
// have priority so a lookup behind an update to the same row sees new data.
// Outputs to the array are registered and frozen while i_halt is high.
//
// Optional feature (macro STAT_ARB_FAIRNESS_EN): a 4-bit starvation counter
// counts update grants while a lookup waits; at STARVE_LIMIT the lookup wins
// the next issue. Without the macro, update priority is strict.
//
// Ports:
//   clk, arst                         clock, asynchronous active-high reset
//   i_halt                            pipeline stall (no accept, no issue)
//   i_lkp_valid/tag/addr, o_lkp_ready lookup request port
//   i_upd_valid/addr/data/wmask,
//   o_upd_ready                       update request port
//   i_sa_ready                        status array can take a request
//   o_sa_tag/addr/data/wen/wmask/valid registered request to status array
// -----------------------------------------------------------------------------
module status_array_arbiter
    import status_array_arbiter_pkg::*;
#(
    parameter int TAG_WIDTH    = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  i_halt,
    input  logic                  i_lkp_valid,
    input  logic [TAG_WIDTH-1:0]  i_lkp_tag,
    input  logic [ADDR_WIDTH-1:0] i_lkp_addr,
    output logic                  o_lkp_ready,
    input  logic                  i_upd_valid,
    input  logic [ADDR_WIDTH-1:0] i_upd_addr,
    input  logic [ROW_WIDTH-1:0]  i_upd_data,
    input  logic [NUM_BLOCKS-1:0] i_upd_wmask,
    output logic                  o_upd_ready,
    input  logic                  i_sa_ready,
    output logic [TAG_WIDTH-1:0]  o_sa_tag,
    output logic [ADDR_WIDTH-1:0] o_sa_addr,
    output logic [ROW_WIDTH-1:0]  o_sa_data,
    output logic                  o_sa_wen,
    output logic [NUM_BLOCKS-1:0] o_sa_wmask,
    output logic                  o_sa_valid
);

    localparam int LKP_W = TAG_WIDTH + ADDR_WIDTH;

    arb_state_e state_d, state_q;

    logic                  run_s, issue_s, pick_upd_s, upd_issue_s, lkp_issue_s;
    logic                  lkp_full_s, upd_full_s, lkp_load_s, upd_load_s;
    logic [LKP_W-1:0]      lkp_held_s;
    upd_req_t              upd_in_s, upd_held_s;
    logic [UPD_REQ_W-1:0]  upd_held_raw_s;

    logic [TAG_WIDTH-1:0]  sa_tag_d, sa_tag_q;
    logic [ADDR_WIDTH-1:0] sa_addr_d, sa_addr_q;
    logic [ROW_WIDTH-1:0]  sa_data_d, sa_data_q;
    logic                  sa_wen_d, sa_wen_q;
    logic [NUM_BLOCKS-1:0] sa_wmask_d, sa_wmask_q;
    logic                  sa_valid_d, sa_valid_q;

    // Next state: wait for the array to report ready once, then run until reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT_RDY: begin
                if (i_sa_ready) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_WAIT_RDY;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_WAIT_RDY;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= ST_WAIT_RDY;
        end else begin
            state_q <= state_d;
        end
    end

    assign run_s   = (state_q == ST_RUN);
    assign issue_s = run_s & ~i_halt & i_sa_ready & (lkp_full_s | upd_full_s);

`ifdef STAT_ARB_FAIRNESS_EN
    logic [3:0] starve_d, starve_q;
    logic       lkp_forced_s;

    assign lkp_forced_s = lkp_full_s & (starve_q >= 4'(STARVE_LIMIT));
    assign pick_upd_s   = upd_full_s & ~lkp_forced_s;

    // Starvation count: only meaningful while a lookup is actually waiting.
    always_comb begin
        starve_d = starve_q;
        if (lkp_issue_s || !lkp_full_s) begin
            starve_d = 4'd0;
        end else if (upd_issue_s) begin
            starve_d = sat_inc4(starve_q);
        end else begin
            starve_d = starve_q;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            starve_q <= 4'd0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    logic [3:0] unused_starve_limit_s;

    assign unused_starve_limit_s = 4'(STARVE_LIMIT);
    assign pick_upd_s            = upd_full_s;
`endif

    assign upd_issue_s = issue_s & pick_upd_s;
    assign lkp_issue_s = issue_s & ~pick_upd_s;

    // A port is ready when empty or when its held request leaves this edge.
    assign o_lkp_ready = run_s & ~i_halt & (~lkp_full_s | lkp_issue_s);
    assign o_upd_ready = run_s & ~i_halt & (~upd_full_s | upd_issue_s);
    assign lkp_load_s  = i_lkp_valid & o_lkp_ready;
    assign upd_load_s  = i_upd_valid & o_upd_ready;

    assign upd_in_s   = '{addr: i_upd_addr, data: i_upd_data, wmask: i_upd_wmask};
    assign upd_held_s = upd_req_t'(upd_held_raw_s);

    status_req_holder #(.WIDTH(LKP_W)) u_lkp_holder (
        .clk     (clk),
        .arst    (arst),
        .i_load  (lkp_load_s),
        .i_issue (lkp_issue_s),
        .i_data  ({i_lkp_tag, i_lkp_addr}),
        .o_full  (lkp_full_s),
        .o_data  (lkp_held_s)
    );

    status_req_holder #(.WIDTH(UPD_REQ_W)) u_upd_holder (
        .clk     (clk),
        .arst    (arst),
        .i_load  (upd_load_s),
        .i_issue (upd_issue_s),
        .i_data  (upd_in_s),
        .o_full  (upd_full_s),
        .o_data  (upd_held_raw_s)
    );

    // Output channel: load the winner on issue, drop valid otherwise, freeze on halt.
    always_comb begin
        sa_tag_d   = sa_tag_q;
        sa_addr_d  = sa_addr_q;
        sa_data_d  = sa_data_q;
        sa_wen_d   = sa_wen_q;
        sa_wmask_d = sa_wmask_q;
        sa_valid_d = sa_valid_q;
        if (upd_issue_s) begin
            sa_valid_d = 1'b1;
            sa_wen_d   = 1'b1;
            sa_tag_d   = {TAG_WIDTH{1'b0}};
            sa_addr_d  = upd_held_s.addr;
            sa_data_d  = upd_held_s.data;
            sa_wmask_d = upd_held_s.wmask;
        end else if (lkp_issue_s) begin
            sa_valid_d = 1'b1;
            sa_wen_d   = 1'b0;
            sa_tag_d   = lkp_held_s[LKP_W-1:ADDR_WIDTH];
            sa_addr_d  = lkp_held_s[ADDR_WIDTH-1:0];
            sa_data_d  = {ROW_WIDTH{1'b0}};
            sa_wmask_d = {NUM_BLOCKS{1'b0}};
        end else if (!i_halt) begin
            sa_valid_d = 1'b0;
        end else begin
            sa_valid_d = sa_valid_q;
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            sa_tag_q   <= {TAG_WIDTH{1'b0}};
            sa_addr_q  <= {ADDR_WIDTH{1'b0}};
            sa_data_q  <= {ROW_WIDTH{1'b0}};
            sa_wen_q   <= 1'b0;
            sa_wmask_q <= {NUM_BLOCKS{1'b0}};
            sa_valid_q <= 1'b0;
        end else begin
            sa_tag_q   <= sa_tag_d;
            sa_addr_q  <= sa_addr_d;
            sa_data_q  <= sa_data_d;
            sa_wen_q   <= sa_wen_d;
            sa_wmask_q <= sa_wmask_d;
            sa_valid_q <= sa_valid_d;
        end
    end

    assign o_sa_tag   = sa_tag_q;
    assign o_sa_addr  = sa_addr_q;
    assign o_sa_data  = sa_data_q;
    assign o_sa_wen   = sa_wen_q;
    assign o_sa_wmask = sa_wmask_q;
    assign o_sa_valid = sa_valid_q;

endmodule
